uart_rx_os: RTL and testbench

Parametrised oversampling UART receiver, the next-generation RX engine behind the UART register block's RX FIFO.
- Generalises the fixed 8-bit receiver:
  - runtime data length (5–8 bits, MAX_DATA_BITS-wide output)
  - parameterised oversampling with 3-sample majority voting
  - false-start rejection and break detection
  - per-word error flags and overrun signalling
- Output is a one-entry valid/ready holding stage feeding the RX FIFO.

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_baud_gen.sv | 27 ++
 rtl/uart_rx_os.sv | 174 +++++++++++++++++
 tb/tb_uart_rx_os.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types: RX state encoding, data-length codes, status flags and control-register
// layout.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBrkWait
  } uart_rx_state_e;

  localparam logic [1:0] UART_DLEN_5 = 2'd0;
  localparam logic [1:0] UART_DLEN_6 = 2'd1;
  localparam logic [1:0] UART_DLEN_7 = 2'd2;
  localparam logic [1:0] UART_DLEN_8 = 2'd3;

  typedef struct packed {
    logic brk;
    logic frame_err;
    logic parity_err;
  } uart_rx_status_t;

  typedef struct packed {
    logic [1:0] data_len;
    logic       parity_type;
    logic       parity_en;
    logic       clk_en;
  } cfg_reg_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Programmable divider producing the oversample tick; shared by the RX and TX engines.
module uart_baud_gen #(
  parameter int unsigned DIV_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 clr_i,
  input  logic [DIV_WIDTH-1:0] clk_div_i,
  output logic                 tick_o
);

  logic [DIV_WIDTH-1:0] cnt_q;

  assign tick_o = en_i && !clr_i && (cnt_q == clk_div_i);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (!en_i || clr_i || tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: majority-voted bits, runtime data length, parity, break and
// overrun reporting, with a one-entry valid/ready holding stage.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE    = 16,
  parameter int unsigned MAX_DATA_BITS = 8,
  parameter int unsigned DIV_WIDTH     = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clk_en_i,
  input  logic [DIV_WIDTH-1:0]     clk_div_i,
  input  logic [1:0]               cfg_data_len_i,
  input  logic                     cfg_parity_en_i,
  input  logic                     cfg_parity_type_i,
  input  logic                     rx_i,
  output logic [MAX_DATA_BITS-1:0] data_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic                     parity_err_o,
  output logic                     frame_err_o,
  output logic                     break_o,
  output logic                     overrun_o,
  output logic                     busy_o
);

  localparam int unsigned OsW  = $clog2(OVERSAMPLE);
  localparam int unsigned BitW = $clog2(MAX_DATA_BITS + 1);
  localparam logic [OsW-1:0] SampLo  = OsW'(OVERSAMPLE / 2 - 1);
  localparam logic [OsW-1:0] SampMid = OsW'(OVERSAMPLE / 2);
  localparam logic [OsW-1:0] SampHi  = OsW'(OVERSAMPLE / 2 + 1);
  localparam logic [OsW-1:0] OsLast  = OsW'(OVERSAMPLE - 1);

  uart_rx_state_e           state_q;
  logic [1:0]               sync_q;
  logic [OsW-1:0]           os_cnt_q;
  logic [BitW-1:0]          bit_cnt_q;
  logic [1:0]               samp_q;
  logic [MAX_DATA_BITS-1:0] shift_q;
  logic [MAX_DATA_BITS-1:0] data_q;
  logic                     par_q;
  logic                     valid_q;
  logic                     overrun_q;
  uart_rx_status_t          status_q;
  uart_rx_status_t          status_new;

  logic                     rx_s;
  logic                     os_tick;
  logic                     start_det;
  logic                     bit_done;
  logic                     bit_val;
  logic                     last_bit;
  logic                     commit;
  int unsigned              len_eff;
  logic [MAX_DATA_BITS-1:0] word_new;

  assign rx_s      = sync_q[1];
  assign start_det = clk_en_i && (state_q == StIdle) && !rx_s;

  // Cleared on the start edge so tick phase is aligned to the falling edge.
  uart_baud_gen #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_baud_gen (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .en_i     (clk_en_i),
    .clr_i    (start_det),
    .clk_div_i(clk_div_i),
    .tick_o   (os_tick)
  );

  assign bit_done = os_tick && (os_cnt_q == SampHi);
  assign bit_val  = maj3(samp_q[0], samp_q[1], rx_s);
  assign commit   = clk_en_i && bit_done && (state_q == StStop);

  always_comb begin
    len_eff = 32'(cfg_data_len_i) + 32'd5;
    if (len_eff > MAX_DATA_BITS) len_eff = MAX_DATA_BITS;
  end

  // '>=' keeps a mid-frame length change from stranding the FSM in DATA.
  assign last_bit = (32'(bit_cnt_q) + 32'd1) >= len_eff;
  // Bits enter at the MSB; realign so the word is LSB-justified and zero-extended.
  assign word_new = shift_q >> (MAX_DATA_BITS - len_eff);

  always_comb begin
    status_new.frame_err  = !bit_val;
    status_new.brk        = !bit_val && (shift_q == '0) && !par_q;
    status_new.parity_err = cfg_parity_en_i && ((^shift_q ^ par_q) != cfg_parity_type_i);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      sync_q    <= 2'b11;
      os_cnt_q  <= '0;
      bit_cnt_q <= '0;
      samp_q    <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      data_q    <= '0;
      status_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], rx_i};
      overrun_q <= 1'b0;

      if (commit) begin
        if (!valid_q || ready_i) begin
          data_q   <= word_new;
          status_q <= status_new;
          valid_q  <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && ready_i) begin
        valid_q  <= 1'b0;
        status_q <= '0;
      end

      if (!clk_en_i) begin
        state_q  <= StIdle;
        os_cnt_q <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            os_cnt_q <= '0;
            if (!rx_s) begin
              state_q   <= StStart;
              bit_cnt_q <= '0;
              shift_q   <= '0;
              par_q     <= 1'b0;
            end
          end
          StBrkWait: if (rx_s) state_q <= StIdle;
          default: begin
            if (os_tick) begin
              os_cnt_q <= (os_cnt_q == OsLast) ? '0 : os_cnt_q + OsW'(1);
              if (os_cnt_q == SampLo) samp_q[0] <= rx_s;
              if (os_cnt_q == SampMid) samp_q[1] <= rx_s;
            end
            if (bit_done) begin
              unique case (state_q)
                StStart: state_q <= bit_val ? StIdle : StData;
                StData: begin
                  shift_q   <= {bit_val, shift_q[MAX_DATA_BITS-1:1]};
                  bit_cnt_q <= bit_cnt_q + BitW'(1);
                  if (last_bit) state_q <= cfg_parity_en_i ? StParity : StStop;
                end
                StParity: begin
                  par_q   <= bit_val;
                  state_q <= StStop;
                end
                StStop:  state_q <= status_new.brk ? StBrkWait : StIdle;
                default: state_q <= StIdle;
              endcase
            end
          end
        endcase
      end
    end
  end

  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign parity_err_o = status_q.parity_err;
  assign frame_err_o  = status_q.frame_err;
  assign break_o      = status_q.brk;
  assign overrun_o    = overrun_q;
  assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_os.sv
// Randomised bench for uart_rx_os: frames are built bit by bit on rx_i and the received words
// are compared with a frame-level model.
module tb_uart_rx_os;

  localparam int unsigned OS = 16;
  localparam int unsigned DW = 32;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          clk_en_i;
  logic [DW-1:0] clk_div_i;
  logic [1:0]    cfg_data_len_i;
  logic          cfg_parity_en_i;
  logic          cfg_parity_type_i;
  logic          rx_i;
  logic [7:0]    data_o;
  logic          valid_o;
  logic          ready_i;
  logic          parity_err_o;
  logic          frame_err_o;
  logic          break_o;
  logic          overrun_o;
  logic          busy_o;

  uart_rx_os #(
    .OVERSAMPLE   (OS),
    .MAX_DATA_BITS(8),
    .DIV_WIDTH    (DW)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .clk_en_i         (clk_en_i),
    .clk_div_i        (clk_div_i),
    .cfg_data_len_i   (cfg_data_len_i),
    .cfg_parity_en_i  (cfg_parity_en_i),
    .cfg_parity_type_i(cfg_parity_type_i),
    .rx_i             (rx_i),
    .data_o           (data_o),
    .valid_o          (valid_o),
    .ready_i          (ready_i),
    .parity_err_o     (parity_err_o),
    .frame_err_o      (frame_err_o),
    .break_o          (break_o),
    .overrun_o        (overrun_o),
    .busy_o           (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int bit_cyc = OS;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: transfers, overrun pulses and the first cycle valid_o is seen high.
  logic [10:0] rxq[$];
  int   ovr_pulses = 0;
  int   ovr_cycles = 0;
  int   rise_cyc = -1;
  logic ovr_prev = 1'b0;
  logic valid_prev = 1'b0;

  always @(negedge clk_i) begin
    if (valid_o && ready_i) rxq.push_back({break_o, frame_err_o, parity_err_o, data_o});
    if (overrun_o) ovr_cycles++;
    if (overrun_o && !ovr_prev) ovr_pulses++;
    ovr_prev = overrun_o;
    if (valid_o && !valid_prev) rise_cyc = cyc;
    valid_prev = valid_o;
  end

  // Expected {break, frame_err, parity_err, data} for one frame.
  function automatic logic [10:0] model(input logic [7:0] d, input int nb, input bit pe,
                                        input bit pt, input bit pb, input bit sb);
    int         mask;
    logic [7:0] m;
    int         ones;
    bit         perr;
    bit         brk;
    mask = (1 << nb) - 1;
    m    = d & mask[7:0];
    ones = $countones(m) + int'(pb);
    perr = pe && (((ones % 2) == 1) != pt);
    brk  = !sb && (m == 8'h00) && (!pe || !pb);
    return {brk, !sb, perr, m};
  endfunction

  task automatic hold(input logic v, input int n);
    rx_i = v;
    repeat (n) @(negedge clk_i);
  endtask

  // glitch_bit >= 0 inverts one cycle at one of that data bit's three sample points.
  task automatic send_frame(input logic [7:0] d, input int nb, input bit pe, input bit pb,
                            input bit sb, input int glitch_bit);
    hold(1'b0, bit_cyc);
    for (int i = 0; i < nb; i++) begin
      if (i == glitch_bit) begin
        int g;
        g = 8 + int'($urandom_range(0, 2));
        hold(d[i], g);
        hold(!d[i], 1);
        hold(d[i], bit_cyc - g - 1);
      end else begin
        hold(d[i], bit_cyc);
      end
    end
    if (pe) hold(pb, bit_cyc);
    hold(sb, bit_cyc);
    rx_i = 1'b1;
  endtask

  task automatic expect_word(input string tag, input logic [10:0] exp);
    int t;
    t = 0;
    while (rxq.size() == 0 && t < 4000) begin
      @(negedge clk_i);
      t++;
    end
    check_eq({tag, "_present"}, 32'(rxq.size() > 0), 32'd1);
    if (rxq.size() > 0) check_eq(tag, 32'(rxq.pop_front()), 32'(exp));
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk_i);
    #1 ready_i = v;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    int   lat;
    int   t0;
    int   ovr_base;
    logic [7:0] d;
    int   nb;
    bit   pe, pt, pb, sb;

    rst_ni = 1'b0;
    clk_en_i = 1'b0;
    clk_div_i = '0;
    cfg_data_len_i = 2'd3;
    cfg_parity_en_i = 1'b0;
    cfg_parity_type_i = 1'b0;
    rx_i = 1'b1;
    ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check_eq("rst_flags", 32'({valid_o, parity_err_o, frame_err_o, break_o, overrun_o, busy_o}),
             32'd0);
    check_eq("rst_data", 32'(data_o), 32'd0);
    rst_ni = 1'b1;
    clk_en_i = 1'b1;
    hold(1'b1, 8);

    // 8N1 0xA5 and first-word latency (sync 2 + 9.5 bit times + output register).
    rise_cyc = -1;
    t0 = cyc;
    send_frame(8'hA5, 8, 0, 0, 1, -1);
    lat = rise_cyc - t0;
    check_eq("a5_latency_window", 32'(lat >= 154 && lat <= 158), 32'd1);
    expect_word("a5", model(8'hA5, 8, 0, 0, 0, 1));
    hold(1'b1, 2 * OS);

    // 8-bit odd parity, both parity-bit values.
    cfg_parity_en_i = 1'b1;
    cfg_parity_type_i = 1'b1;
    send_frame(8'h3C, 8, 1, 1, 1, -1);
    expect_word("par_p1", model(8'h3C, 8, 1, 1, 1, 1));
    hold(1'b1, 2 * OS);
    send_frame(8'h3C, 8, 1, 0, 1, -1);
    expect_word("par_p0", model(8'h3C, 8, 1, 1, 0, 1));
    hold(1'b1, 2 * OS);
    cfg_parity_en_i = 1'b0;

    // False start: 4 low ticks.
    hold(1'b0, 4);
    check_eq("fstart_busy", 32'(busy_o), 32'd1);
    hold(1'b1, 3 * OS);
    check_eq("fstart_idle", 32'(busy_o), 32'd0);
    check_eq("fstart_noword", 32'(rxq.size()), 32'd0);

    // One-cycle glitch at a sample point of a random data bit.
    send_frame(8'h55, 8, 0, 0, 1, int'($urandom_range(0, 7)));
    expect_word("glitch55", model(8'h55, 8, 0, 0, 0, 1));
    hold(1'b1, 2 * OS);

    // Break: 12 bit times low, then a clean frame.
    hold(1'b0, 12 * OS);
    expect_word("break", model(8'h00, 8, 0, 0, 0, 0));
    hold(1'b1, 2 * OS);
    check_eq("break_single", 32'(rxq.size()), 32'd0);
    send_frame(8'h7E, 8, 0, 0, 1, -1);
    expect_word("after_brk", model(8'h7E, 8, 0, 0, 0, 1));
    hold(1'b1, 2 * OS);

    // Overrun with consumer stalled.
    set_ready(1'b0);
    ovr_base = ovr_pulses;
    ovr_cycles = 0;
    send_frame(8'h11, 8, 0, 0, 1, -1);
    hold(1'b1, OS);
    send_frame(8'h22, 8, 0, 0, 1, -1);
    hold(1'b1, OS);
    check_eq("ovr_valid", 32'(valid_o), 32'd1);
    check_eq("ovr_held", 32'(data_o), 32'h11);
    check_eq("ovr_pulses", 32'(ovr_pulses - ovr_base), 32'd1);
    check_eq("ovr_width", 32'(ovr_cycles), 32'd1);
    set_ready(1'b1);
    repeat (2) @(negedge clk_i);
    check_eq("ovr_drain_valid", 32'(valid_o), 32'd0);
    expect_word("ovr_word", model(8'h11, 8, 0, 0, 0, 1));
    check_eq("ovr_noextra", 32'(rxq.size()), 32'd0);

    // 5-bit words, then a reset in the middle of a frame.
    cfg_data_len_i = 2'd0;
    send_frame(8'h1F, 5, 0, 0, 1, -1);
    expect_word("len5", model(8'h1F, 5, 0, 0, 0, 1));
    hold(1'b1, 2 * OS);
    ovr_base = ovr_pulses;
    hold(1'b0, OS);
    hold(1'b1, OS);
    hold(1'b0, 5);
    @(posedge clk_i);
    #1 rst_ni = 1'b0;
    rx_i = 1'b1;
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    check_eq("midrst_outs",
             32'({valid_o, parity_err_o, frame_err_o, break_o, overrun_o, busy_o, data_o}), 32'd0);
    hold(1'b1, 2 * OS);
    check_eq("midrst_noword", 32'(rxq.size()), 32'd0);
    check_eq("midrst_noovr", 32'(ovr_pulses - ovr_base), 32'd0);
    send_frame(8'h0A, 5, 0, 0, 1, -1);
    expect_word("midrst_0a", model(8'h0A, 5, 0, 0, 0, 1));
    hold(1'b1, 2 * OS);

    // Random frames over divider, length, parity and stop-bit values.
    for (int k = 0; k < 24; k++) begin
      clk_div_i = DW'($urandom_range(0, 2));
      bit_cyc = OS * (int'(clk_div_i) + 1);
      cfg_data_len_i = 2'($urandom_range(0, 3));
      nb = 5 + int'(cfg_data_len_i);
      pe = 1'($urandom_range(0, 1));
      pt = 1'($urandom_range(0, 1));
      pb = 1'($urandom_range(0, 1));
      sb = ($urandom_range(0, 5) != 0);
      d = 8'($urandom);
      if ($urandom_range(0, 7) == 0) d = 8'h00;
      cfg_parity_en_i = pe;
      cfg_parity_type_i = pt;
      hold(1'b1, 2);
      send_frame(d, nb, pe, pb, sb, -1);
      expect_word($sformatf("rand%0d", k), model(d, nb, pe, pt, pb, sb));
      hold(1'b1, 2 * bit_cyc);
    end
    check_eq("rand_noextra", 32'(rxq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
